gate_bist_seq: RTL

//   Built-in self-test sequencer for the logic_gate block. Drives its a/b inputs

---
 rtl/gate_bist_if.sv | 35 +++
 rtl/gate_bist_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gate_bist_if.sv
// Handshake and stimulus/response bundle between gate_bist_seq and its logic_gate target.
// master = the BIST sequencer, slave = the logic_gate side plus the start requester.
interface gate_bist_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic             and_gate;
  logic             or_gate;
  logic             not_gate;
  logic             nand_gate;
  logic             nor_gate;
  logic             xor_gate;
  logic             xnor_gate;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [6:0]       fail_vec;

  modport master (
    input  start,
    input  and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate,
    output a, b,
    output busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start,
    output and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate,
    input  a, b,
    input  busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_bist_seq.sv
// BIST sequencer for logic_gate: sweeps {a,b} through 00..11, checks all seven gates per vector.
// Optional GATE_BIST_STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module gate_bist_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.master bus
);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // A zero hold still needs one settle cycle so the sample never races the new vector.
  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int CNT_W    = $clog2(HOLD_EFF + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_last;
  logic [6:0]       exp_gates;
  logic [6:0]       obs_gates;
  logic [6:0]       mis_bits;
  logic             any_mis;
  logic [ERR_W-1:0] err_cnt;
  logic [6:0]       fail_vec;
  logic             pass;

  assign settle_last = (settle_cnt == CNT_W'(HOLD_EFF - 1));

  // Expected responses from the registered stimulus; bit order matches fail_vec.
  assign exp_gates = {~(vec[1] ^ vec[0]), vec[1] ^ vec[0], ~(vec[1] | vec[0]),
                      ~(vec[1] & vec[0]), ~vec[1], vec[1] | vec[0], vec[1] & vec[0]};
  assign obs_gates = {bus.xnor_gate, bus.xor_gate, bus.nor_gate, bus.nand_gate,
                      bus.not_gate, bus.or_gate, bus.and_gate};

  // Case inequality so an X or Z returned by the gate counts as a mismatch.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      mis_bits[i] = (obs_gates[i] !== exp_gates[i]);
    end
  end

  assign any_mis = |mis_bits;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_last) state_nxt = CHECK;
      end
      CHECK: begin
        if ((vec == 2'd3) || (STOP_ON_FAIL && any_mis)) state_nxt = DONE;
        else                                            state_nxt = SETTLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      IDLE:    bus.busy = 1'b0;
      SETTLE,
      CHECK:   bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  // Datapath: vector index, settle timer and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 2'd0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            vec        <= 2'd0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
          end
        end
        SETTLE: begin
          if (!settle_last) settle_cnt <= settle_cnt + 1'b1;
        end
        CHECK: begin
          if (any_mis) begin
            fail_vec <= fail_vec | mis_bits;
            if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
          end
          if (state_nxt == SETTLE) begin
            vec        <= vec + 2'd1;
            settle_cnt <= '0;
          end else begin
            // err_cnt still holds the pre-CHECK count, so fold in this vector's result.
            pass <= (err_cnt == '0) && !any_mis;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a        = vec[1];
  assign bus.b        = vec[0];
  assign bus.err_cnt  = err_cnt;
  assign bus.fail_vec = fail_vec;
  assign bus.pass     = pass;

endmodule
